vga_layer_mixer: RTL and testbench



---
 rtl/vga_layer_mixer.sv | 214 +++++++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// VGA layer mixer: priority/colour-key compositing with frame-synced config and fades.
// Ports: clk/rst_n, raster valid+position, packed layers, cfg shadow strobe, fade control, RGB out.
module vga_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int PIXEL_W = 12,
  parameter logic [PIXEL_W-1:0] KEY_COLOR = 12'hF0F,
  parameter logic [PIXEL_W-1:0] BG_COLOR = 12'h000,
  parameter int FADE_STEP = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixels,
  input  logic [NUM_LAYERS-1:0]         layer_enable,
  input  logic [NUM_LAYERS-1:0]         cfg_mask,
  input  logic                          cfg_key_en,
  input  logic                          cfg_wr,
  input  logic                          fade_start,
  input  logic                          fade_dir,
  output logic [3:0]                    vgaRed,
  output logic [3:0]                    vgaGreen,
  output logic [3:0]                    vgaBlue,
  output logic                          out_valid,
  output logic [9:0]                    h_cnt_out,
  output logic [9:0]                    v_cnt_out,
  output logic                          fade_busy,
  output logic [4:0]                    fade_level
);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } fade_state_e;

  localparam logic [5:0] STEP6 = 6'(FADE_STEP);
  localparam logic [4:0] LVL_MAX = 5'd16;

  // Frame tick: first clk at origin after a non-origin position.
  logic pos_zero;
  logic prev_nz_q;
  logic frame_tick;

  assign pos_zero = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign frame_tick = pos_zero && prev_nz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_nz_q <= 1'b0;
    end else begin
      prev_nz_q <= !pos_zero;
    end
  end

  // Shadow / active layer configuration.
  logic [NUM_LAYERS-1:0] sh_mask_q, sh_mask_d;
  logic                  sh_key_q, sh_key_d;
  logic [NUM_LAYERS-1:0] act_mask_q, act_mask_d;
  logic                  act_key_q, act_key_d;
  logic                  pend_q, pend_d;

  always_comb begin
    sh_mask_d = sh_mask_q;
    sh_key_d = sh_key_q;
    act_mask_d = act_mask_q;
    act_key_d = act_key_q;
    pend_d = pend_q;
    if (cfg_wr) begin
      sh_mask_d = cfg_mask;
      sh_key_d = cfg_key_en;
      pend_d = 1'b1;
    end
    // Uses the _d shadows so a write on the tick cycle applies at once.
    if (frame_tick && pend_d) begin
      act_mask_d = sh_mask_d;
      act_key_d = sh_key_d;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_mask_q <= '1;
      sh_key_q <= 1'b0;
      act_mask_q <= '1;
      act_key_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sh_mask_q <= sh_mask_d;
      sh_key_q <= sh_key_d;
      act_mask_q <= act_mask_d;
      act_key_q <= act_key_d;
      pend_q <= pend_d;
    end
  end

  // Fade FSM.
  fade_state_e state_q, state_d, dir_state;
  logic [4:0]  level_q, level_d;
  logic [5:0]  lvl6;
  logic [5:0]  dn6;
  logic [5:0]  up6;
  logic [5:0]  up_sum;

  assign lvl6 = {1'b0, level_q};
  assign dn6 = (lvl6 > STEP6) ? (lvl6 - STEP6) : 6'd0;
  assign up_sum = lvl6 + STEP6;
  assign up6 = (up_sum >= 6'd16) ? 6'd16 : up_sum;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dir_state = state_q;
    if (fade_start) begin
      dir_state = fade_dir ? FADE_IN : FADE_OUT;
    end
    state_d = dir_state;
    // A start coinciding with the tick steps in the new direction.
    if (frame_tick) begin
      unique case (dir_state)
        FADE_OUT: begin
          level_d = dn6[4:0];
          if (dn6 == 6'd0) state_d = IDLE;
        end
        FADE_IN: begin
          level_d = up6[4:0];
          if (up6 == 6'd16) state_d = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= LVL_MAX;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign fade_busy = (state_q != IDLE);
  assign fade_level = level_q;

  // Stage 1: lowest-index qualifying layer wins.
  logic [PIXEL_W-1:0] sel_pix;
  logic               found;

  always_comb begin
    sel_pix = BG_COLOR;
    found = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_enable[i] && act_mask_q[i] &&
          (!act_key_q ||
           layer_pixels[i*PIXEL_W +: PIXEL_W] != KEY_COLOR)) begin
        sel_pix = layer_pixels[i*PIXEL_W +: PIXEL_W];
        found = 1'b1;
      end
    end
    if (!valid) sel_pix = '0;
  end

  logic [PIXEL_W-1:0] pix1_q;
  logic               vld1_q;
  logic [9:0]         h1_q, v1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix1_q <= '0;
      vld1_q <= 1'b0;
      h1_q <= '0;
      v1_q <= '0;
    end else begin
      pix1_q <= sel_pix;
      vld1_q <= valid;
      h1_q <= h_cnt;
      v1_q <= v_cnt;
    end
  end

  // Stage 2: brightness scale, level sampled as the pixel enters.
  function automatic logic [3:0] scale(
    input logic [3:0] c,
    input logic [4:0] lvl
  );
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, lvl};
    return p[7:4];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vgaRed <= '0;
      vgaGreen <= '0;
      vgaBlue <= '0;
      out_valid <= 1'b0;
      h_cnt_out <= '0;
      v_cnt_out <= '0;
    end else begin
      vgaRed <= scale(pix1_q[11:8], level_q);
      vgaGreen <= scale(pix1_q[7:4], level_q);
      vgaBlue <= scale(pix1_q[3:0], level_q);
      out_valid <= vld1_q;
      h_cnt_out <= h1_q;
      v_cnt_out <= v1_q;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed testbench for vga_layer_mixer.
// Each task drives one scenario and checks against hand-computed values.
module tb_vga_layer_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [9:0]  h_cnt, v_cnt;
  logic [47:0] layer_pixels;
  logic [3:0]  layer_enable;
  logic [3:0]  cfg_mask;
  logic        cfg_key_en, cfg_wr;
  logic        fade_start, fade_dir;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic        out_valid;
  logic [9:0]  h_cnt_out, v_cnt_out;
  logic        fade_busy;
  logic [4:0]  fade_level;
  logic [11:0] rgb;

  int pass_cnt = 0;
  int total = 0;

  assign rgb = {vgaRed, vgaGreen, vgaBlue};

  always #5 clk = ~clk;

  vga_layer_mixer #(.FADE_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .layer_pixels(layer_pixels),
    .layer_enable(layer_enable),
    .cfg_mask(cfg_mask), .cfg_key_en(cfg_key_en),
    .cfg_wr(cfg_wr), .fade_start(fade_start),
    .fade_dir(fade_dir),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen),
    .vgaBlue(vgaBlue), .out_valid(out_valid),
    .h_cnt_out(h_cnt_out), .v_cnt_out(v_cnt_out),
    .fade_busy(fade_busy), .fade_level(fade_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step2();
    step();
    step();
  endtask

  task automatic frame_tick();
    h_cnt = 0;
    v_cnt = 0;
    step();
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    step();
  endtask

  task automatic write_cfg(input logic [3:0] m, input logic k);
    cfg_mask = m;
    cfg_key_en = k;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    layer_pixels = {12'h111, 12'h222, 12'hABC, 12'h123};
    layer_enable = 4'b1111;
    step();
    step();
    step();
    total++;
    if (rgb !== 12'h000 || out_valid !== 1'b0)
      $display("FAIL reset_out: rgb=%h vld=%b exp 000 0", rgb, out_valid);
    else pass_cnt++;
    total++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0)
      $display("FAIL reset_fade: lvl=%0d busy=%b exp 16 0", fade_level, fade_busy);
    else pass_cnt++;
    total++;
    if (h_cnt_out !== 10'd0 || v_cnt_out !== 10'd0)
      $display("FAIL reset_pos: h=%0d v=%0d exp 0 0", h_cnt_out, v_cnt_out);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    layer_pixels = {12'h111, 12'h222, 12'hABC, 12'h123};
    layer_enable = 4'b0010;
    step2();
    total++;
    if (rgb !== 12'hABC)
      $display("FAIL prio_l1: got %h exp ABC", rgb);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b1 || h_cnt_out !== 10'd5 || v_cnt_out !== 10'd3)
      $display("FAIL prio_pos: vld=%b h=%0d v=%0d exp 1 5 3", out_valid, h_cnt_out, v_cnt_out);
    else pass_cnt++;
    layer_enable = 4'b0011;
    step();
    total++;
    if (rgb !== 12'hABC)
      $display("FAIL latency_1: got %h exp ABC", rgb);
    else pass_cnt++;
    step();
    total++;
    if (rgb !== 12'h123)
      $display("FAIL prio_l0: got %h exp 123", rgb);
    else pass_cnt++;
  endtask

  task automatic test_key();
    write_cfg(4'b1111, 1'b1);
    layer_pixels = {12'h111, 12'h222, 12'h0F0, 12'hF0F};
    layer_enable = 4'b0011;
    step2();
    total++;
    if (rgb !== 12'hF0F)
      $display("FAIL key_pending: got %h exp F0F", rgb);
    else pass_cnt++;
    frame_tick();
    step2();
    total++;
    if (rgb !== 12'h0F0)
      $display("FAIL key_l1: got %h exp 0F0", rgb);
    else pass_cnt++;
    layer_pixels = {4{12'hF0F}};
    layer_enable = 4'b1111;
    step2();
    total++;
    if (rgb !== 12'h000)
      $display("FAIL key_bg: got %h exp 000", rgb);
    else pass_cnt++;
    layer_pixels = {12'h111, 12'h222, 12'hABC, 12'h123};
    valid = 1'b0;
    step2();
    total++;
    if (rgb !== 12'h000 || out_valid !== 1'b0)
      $display("FAIL invalid: rgb=%h vld=%b exp 000 0", rgb, out_valid);
    else pass_cnt++;
    valid = 1'b1;
    write_cfg(4'b1111, 1'b0);
    frame_tick();
  endtask

  task automatic test_shadow();
    layer_pixels = {12'h111, 12'h456, 12'hABC, 12'h123};
    layer_enable = 4'b0111;
    write_cfg(4'b1110, 1'b0);
    step2();
    total++;
    if (rgb !== 12'h123)
      $display("FAIL shadow_hold: got %h exp 123", rgb);
    else pass_cnt++;
    frame_tick();
    step2();
    total++;
    if (rgb !== 12'hABC)
      $display("FAIL shadow_apply: got %h exp ABC", rgb);
    else pass_cnt++;
    write_cfg(4'b1111, 1'b0);
    write_cfg(4'b1100, 1'b0);
    frame_tick();
    step2();
    total++;
    if (rgb !== 12'h456)
      $display("FAIL shadow_last: got %h exp 456", rgb);
    else pass_cnt++;
    // cfg_wr on the tick cycle itself
    cfg_mask = 4'b1110;
    cfg_key_en = 1'b0;
    cfg_wr = 1'b1;
    h_cnt = 0;
    v_cnt = 0;
    step();
    cfg_wr = 1'b0;
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    step2();
    total++;
    if (rgb !== 12'hABC)
      $display("FAIL cfg_coincide: got %h exp ABC", rgb);
    else pass_cnt++;
    write_cfg(4'b1111, 1'b0);
    frame_tick();
  endtask

  task automatic test_fade_out();
    layer_pixels = {12'h111, 12'h222, 12'hABC, 12'hFFF};
    layer_enable = 4'b0001;
    fade_dir = 1'b0;
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    total++;
    if (fade_busy !== 1'b1 || fade_level !== 5'd16)
      $display("FAIL fade_start: busy=%b lvl=%0d exp 1 16", fade_busy, fade_level);
    else pass_cnt++;
    frame_tick();
    total++;
    if (fade_level !== 5'd12)
      $display("FAIL fade_12: got %0d exp 12", fade_level);
    else pass_cnt++;
    step2();
    total++;
    if (rgb !== 12'hBBB)
      $display("FAIL pix_12: got %h exp BBB", rgb);
    else pass_cnt++;
    frame_tick();
    step2();
    total++;
    if (fade_level !== 5'd8 || rgb !== 12'h777)
      $display("FAIL fade_8: lvl=%0d rgb=%h exp 8 777", fade_level, rgb);
    else pass_cnt++;
    frame_tick();
    total++;
    if (fade_level !== 5'd4 || fade_busy !== 1'b1)
      $display("FAIL fade_4: lvl=%0d busy=%b exp 4 1", fade_level, fade_busy);
    else pass_cnt++;
    frame_tick();
    step();
    total++;
    if (fade_level !== 5'd0 || fade_busy !== 1'b0)
      $display("FAIL fade_0: lvl=%0d busy=%b exp 0 0", fade_level, fade_busy);
    else pass_cnt++;
    step();
    total++;
    if (rgb !== 12'h000)
      $display("FAIL pix_0: got %h exp 000", rgb);
    else pass_cnt++;
  endtask

  task automatic test_fade_in_dedupe();
    fade_dir = 1'b1;
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    h_cnt = 0;
    v_cnt = 0;
    for (int i = 0; i < 4; i++) step();
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    step();
    total++;
    if (fade_level !== 5'd4 || fade_busy !== 1'b1)
      $display("FAIL dedupe: lvl=%0d busy=%b exp 4 1", fade_level, fade_busy);
    else pass_cnt++;
    frame_tick();
    frame_tick();
    frame_tick();
    total++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0)
      $display("FAIL fade_in_16: lvl=%0d busy=%b exp 16 0", fade_level, fade_busy);
    else pass_cnt++;
  endtask

  task automatic test_limit();
    fade_dir = 1'b1;
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    total++;
    if (fade_busy !== 1'b1)
      $display("FAIL limit_busy: got %b exp 1", fade_busy);
    else pass_cnt++;
    frame_tick();
    total++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0)
      $display("FAIL limit_idle: lvl=%0d busy=%b exp 16 0", fade_level, fade_busy);
    else pass_cnt++;
  endtask

  task automatic test_start_on_tick_and_reset();
    fade_dir = 1'b0;
    fade_start = 1'b1;
    h_cnt = 0;
    v_cnt = 0;
    step();
    fade_start = 1'b0;
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    step();
    total++;
    if (fade_level !== 5'd12 || fade_busy !== 1'b1)
      $display("FAIL start_on_tick: lvl=%0d busy=%b exp 12 1", fade_level, fade_busy);
    else pass_cnt++;
    write_cfg(4'b1110, 1'b0);
    frame_tick();
    total++;
    if (fade_level !== 5'd8)
      $display("FAIL pre_reset: got %0d exp 8", fade_level);
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    total++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0 || rgb !== 12'h000 || out_valid !== 1'b0)
      $display("FAIL mid_reset: lvl=%0d busy=%b rgb=%h vld=%b exp 16 0 000 0",
               fade_level, fade_busy, rgb, out_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    layer_pixels = {12'h111, 12'h222, 12'hABC, 12'h123};
    layer_enable = 4'b0011;
    step2();
    total++;
    if (rgb !== 12'h123)
      $display("FAIL reset_mask: got %h exp 123", rgb);
    else pass_cnt++;
    // Reset held at origin: no tick until position leaves and returns.
    h_cnt = 0;
    v_cnt = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    fade_dir = 1'b0;
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    step();
    step();
    total++;
    if (fade_level !== 5'd16)
      $display("FAIL no_tick_after_reset: got %0d exp 16", fade_level);
    else pass_cnt++;
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    step();
    frame_tick();
    total++;
    if (fade_level !== 5'd12)
      $display("FAIL first_tick: got %0d exp 12", fade_level);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    h_cnt = 10'd5;
    v_cnt = 10'd3;
    layer_pixels = '0;
    layer_enable = '0;
    cfg_mask = 4'b1111;
    cfg_key_en = 1'b0;
    cfg_wr = 1'b0;
    fade_start = 1'b0;
    fade_dir = 1'b0;
    #2;
    test_reset();
    test_priority();
    test_key();
    test_shadow();
    test_fade_out();
    test_fade_in_dedupe();
    test_limit();
    test_start_on_tick_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
